// File: rtl/nios_accelerometer_fir_pkg.sv
// Shared constants and types for the accelerometer FIR scheduler.
// Address map, status bit layout and scheduler state encoding.
package nios_accelerometer_fir_pkg;

    localparam logic [2:0] ADDR_SAMPLE_X = 3'd0;
    localparam logic [2:0] ADDR_SAMPLE_Y = 3'd1;
    localparam logic [2:0] ADDR_SAMPLE_Z = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_RESULT_X = 3'd4;
    localparam logic [2:0] ADDR_RESULT_Y = 3'd5;
    localparam logic [2:0] ADDR_RESULT_Z = 3'd6;

    localparam int ST_PEND_LSB = 0;
    localparam int ST_RVAL_LSB = 4;
    localparam int ST_BUSY     = 8;
    localparam int ST_TOUT     = 9;
    localparam int ST_OVR_LSB  = 12;

    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    function automatic logic [1:0] next_ch(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

endpackage

// File: rtl/nios_accelerometer_rr_arbiter.sv
// Three-way round-robin arbiter; search starts after the last
// granted channel, so after reset channel 0 has top priority.
module nios_accelerometer_rr_arbiter
    import nios_accelerometer_fir_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       any_req
);

    logic [1:0] last;
    logic [1:0] c;
    logic       found;

    assign any_req = |req;

    always_comb begin
        grant = 2'd0;
        found = 1'b0;
        c     = last;
        for (int i = 0; i < 3; i++) begin
            c = next_ch(c);
            if (!found && req[c]) begin
                grant = c;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= 2'd2;
        end else if (advance && any_req) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/nios_accelerometer_fir_scheduler.sv
// Avalon-MM front end sharing one FIR engine between the x/y/z
// accelerometer axes with round-robin issue and per-axis results.
module nios_accelerometer_fir_scheduler
    import nios_accelerometer_fir_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 3,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] fir_in_data,
    output logic              fir_in_valid,
    input  logic              fir_in_ready,
    output logic [1:0]        fir_ch_sel,
    input  logic [DATA_W-1:0] fir_out_data,
    input  logic              fir_out_valid,
    output logic              irq
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t state, state_nxt;

    logic [DATA_W-1:0] hold   [NUM_CH];
    logic [DATA_W-1:0] result [NUM_CH];

    logic [2:0] pending, pend_nxt;
    logic [2:0] result_valid, rv_nxt;
    logic [2:0] overrun, ovr_nxt;
    logic       timeout_st, to_nxt;
    logic [7:0] tcnt;
    logic [1:0] cur, gidx;
    logic       any_req;
    logic       grant_now, hs, cap, tout;
    logic       wr, wr_st;
    logic [2:0] wr_smp;
    logic [31:0] status;

    assign wr     = chipselect & ~write_n;
    assign wr_st  = wr & (address == ADDR_STATUS);
    assign wr_smp = {wr & (address == ADDR_SAMPLE_Z),
                     wr & (address == ADDR_SAMPLE_Y),
                     wr & (address == ADDR_SAMPLE_X)};
    assign irq    = |result_valid;

    nios_accelerometer_rr_arbiter u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (pending),
        .advance (grant_now),
        .grant   (gidx),
        .any_req (any_req)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_now = 1'b0;
        hs        = 1'b0;
        cap       = 1'b0;
        tout      = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    grant_now = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (fir_in_ready) begin
                    hs        = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (fir_out_valid) begin
                    cap       = 1'b1;
                    state_nxt = IDLE;
                end else if (tcnt == TMO_LAST) begin
                    tout      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Hardware sets are applied after W1C clears so a set always wins.
    always_comb begin
        pend_nxt = pending;
        rv_nxt   = result_valid
                 & ~(wr_st ? writedata[ST_RVAL_LSB +: 3] : 3'b000);
        ovr_nxt  = overrun
                 & ~(wr_st ? writedata[ST_OVR_LSB +: 3] : 3'b000);
        to_nxt   = timeout_st & ~(wr_st & writedata[ST_TOUT]);
        if (tout) begin
            to_nxt = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            if (grant_now && gidx == 2'(k)) begin
                pend_nxt[k] = 1'b0;
            end
            if (wr_smp[k]) begin
                pend_nxt[k] = 1'b1;
                if (pending[k] && !(grant_now && gidx == 2'(k))) begin
                    ovr_nxt[k] = 1'b1;
                end
            end
            if (cap && cur == 2'(k)) begin
                rv_nxt[k] = 1'b1;
                if (result_valid[k]) begin
                    ovr_nxt[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                hold[k]   <= '0;
                result[k] <= '0;
            end
            pending      <= '0;
            result_valid <= '0;
            overrun      <= '0;
            timeout_st   <= 1'b0;
            tcnt         <= '0;
            cur          <= '0;
            fir_in_valid <= 1'b0;
            fir_in_data  <= '0;
            fir_ch_sel   <= '0;
        end else begin
            pending      <= pend_nxt;
            result_valid <= rv_nxt;
            overrun      <= ovr_nxt;
            timeout_st   <= to_nxt;
            for (int k = 0; k < 3; k++) begin
                if (wr_smp[k]) begin
                    hold[k] <= writedata[DATA_W-1:0];
                end
            end
            if (grant_now) begin
                cur          <= gidx;
                fir_in_valid <= 1'b1;
                fir_in_data  <= hold[gidx];
                fir_ch_sel   <= gidx;
            end
            if (hs) begin
                fir_in_valid <= 1'b0;
                tcnt         <= '0;
            end else if (state == WAIT) begin
                tcnt <= tcnt + 8'd1;
            end
            if (cap) begin
                result[cur] <= fir_out_data;
            end
        end
    end

    always_comb begin
        status                      = '0;
        status[ST_PEND_LSB +: 3]    = pending;
        status[ST_RVAL_LSB +: 3]    = result_valid;
        status[ST_BUSY]             = (state != IDLE);
        status[ST_TOUT]             = timeout_st;
        status[ST_OVR_LSB +: 3]     = overrun;
    end

    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_SAMPLE_X: readdata = 32'(hold[0]);
            ADDR_SAMPLE_Y: readdata = 32'(hold[1]);
            ADDR_SAMPLE_Z: readdata = 32'(hold[2]);
            ADDR_STATUS:   readdata = status;
            ADDR_RESULT_X: readdata = 32'(result[0]);
            ADDR_RESULT_Y: readdata = 32'(result[1]);
            ADDR_RESULT_Z: readdata = 32'(result[2]);
            default:       readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_accelerometer_fir_scheduler.sv
// Directed bench: issue scoreboard checked on each FIR handshake,
// plus register/status checks around each scenario.
module tb_nios_accelerometer_fir_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] fir_in_data;
    logic        fir_in_valid;
    logic        fir_in_ready;
    logic [1:0]  fir_ch_sel;
    logic [31:0] fir_out_data = '0;
    logic        fir_out_valid = 1'b0;
    logic        irq;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0;
    int          n_chk = 0;
    int          fir_lat = 3;
    int          resp_cnt = 0;
    logic [31:0] resp_data = '0;

    nios_accelerometer_fir_scheduler dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .chipselect    (chipselect),
        .write_n       (write_n),
        .writedata     (writedata),
        .readdata      (readdata),
        .fir_in_data   (fir_in_data),
        .fir_in_valid  (fir_in_valid),
        .fir_in_ready  (fir_in_ready),
        .fir_ch_sel    (fir_ch_sel),
        .fir_out_data  (fir_out_data),
        .fir_out_valid (fir_out_valid),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fir_f(input logic [31:0] x);
        return x + 32'h333;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input logic [2:0] a,
                      input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic push(input logic [1:0] ch, input logic [31:0] d);
        exp_t e;
        e.ch   = ch;
        e.data = d;
        sb.push_back(e);
    endtask

    // FIR model plus issue scoreboard, driven away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        fir_out_valid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                fir_out_valid = 1'b1;
                fir_out_data  = resp_data;
            end
        end
        if (reset_n && fir_in_valid && fir_in_ready) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("issue_ch", 32'(fir_ch_sel), 32'(e.ch));
                chk("issue_data", fir_in_data, e.data);
            end
            resp_cnt  = fir_lat;
            resp_data = fir_f(fir_in_data);
        end
    end

    initial begin
        reset_n      = 1'b0;
        address      = 3'd0;
        chipselect   = 1'b0;
        write_n      = 1'b1;
        writedata    = '0;
        fir_in_ready = 1'b1;
        #2;
        chk("rst_valid", 32'(fir_in_valid), 32'd0);
        chk("rst_data", fir_in_data, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rd("rst_status", 3'd3, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // single sample on x
        push(2'd0, 32'h123);
        wr(3'd0, 32'h123);
        chk("t1_valid_n1", 32'(fir_in_valid), 32'd0);
        rd("t1_status_n1", 3'd3, 32'h001);
        @(posedge clk); #1;
        chk("t1_valid_n2", 32'(fir_in_valid), 32'd1);
        chk("t1_data_n2", fir_in_data, 32'h123);
        chk("t1_ch_n2", 32'(fir_ch_sel), 32'd0);
        rd("t1_status_n2", 3'd3, 32'h100);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_irq_pre", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("t1_irq", 32'(irq), 32'd1);
        rd("t1_res_x", 3'd4, 32'h456);
        rd("t1_status", 3'd3, 32'h010);
        wr(3'd3, 32'h10);
        chk("t1_irq_clr", 32'(irq), 32'd0);
        rd("t1_addr7", 3'd7, 32'h0);

        // back-to-back x, y, z
        fir_lat = 1;
        push(2'd0, 32'h1000);
        push(2'd1, 32'h2000);
        push(2'd2, 32'h3000);
        wr(3'd0, 32'h1000);
        wr(3'd1, 32'h2000);
        wr(3'd2, 32'h3000);
        repeat (20) @(posedge clk);
        #1;
        rd("t2_status", 3'd3, 32'h070);
        rd("t2_res_x", 3'd4, fir_f(32'h1000));
        @(posedge clk); #1;
        rd("t2_res_y", 3'd5, fir_f(32'h2000));
        rd("t2_res_z", 3'd6, fir_f(32'h3000));
        wr(3'd3, 32'h70);

        // overwrite of a pending sample while busy
        fir_lat = 6;
        push(2'd0, 32'h111);
        push(2'd1, 32'hB);
        wr(3'd0, 32'h111);
        @(posedge clk); #1;
        wr(3'd1, 32'hA);
        wr(3'd1, 32'hB);
        rd("t3_status_ovr", 3'd3, 32'h2102);
        repeat (25) @(posedge clk);
        #1;
        rd("t3_status", 3'd3, 32'h2030);
        rd("t3_res_y", 3'd5, fir_f(32'hB));
        wr(3'd3, 32'h7270);

        // backpressure on fir_in_ready
        fir_lat      = 1;
        fir_in_ready = 1'b0;
        push(2'd2, 32'h2222);
        wr(3'd2, 32'h2222);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_valid_hold", 32'(fir_in_valid), 32'd1);
            chk("t4_data_hold", fir_in_data, 32'h2222);
            @(posedge clk); #1;
        end
        chk("t4_ch_hold", 32'(fir_ch_sel), 32'd2);
        fir_in_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_valid_drop", 32'(fir_in_valid), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        rd("t4_res_z", 3'd6, fir_f(32'h2222));
        wr(3'd3, 32'h70);

        // missing FIR result -> timeout, late result ignored
        fir_lat = 300;
        push(2'd0, 32'h77);
        wr(3'd0, 32'h77);
        repeat (249) @(posedge clk);
        #1;
        rd("t5_busy", 3'd3, 32'h100);
        repeat (12) @(posedge clk);
        #1;
        rd("t5_timeout", 3'd3, 32'h200);
        repeat (50) @(posedge clk);
        #1;
        rd("t5_res_keep", 3'd4, fir_f(32'h111));
        rd("t5_status_late", 3'd3, 32'h200);
        wr(3'd3, 32'h200);

        // reset while waiting on the FIR
        fir_lat = 8;
        push(2'd1, 32'h55);
        wr(3'd1, 32'h55);
        repeat (3) @(posedge clk);
        #1;
        rd("t6_busy", 3'd3, 32'h100);
        reset_n = 1'b0;
        #1;
        chk("t6_valid_rst", 32'(fir_in_valid), 32'd0);
        chk("t6_irq_rst", 32'(irq), 32'd0);
        rd("t6_status_rst", 3'd3, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rd("t6_res_y", 3'd5, 32'h0);
        rd("t6_status_idle", 3'd3, 32'h0);
        fir_lat = 1;
        push(2'd2, 32'h3C);
        wr(3'd2, 32'h3C);
        repeat (8) @(posedge clk);
        #1;
        rd("t6_res_z", 3'd6, fir_f(32'h3C));
        rd("t6_status", 3'd3, 32'h040);
        chk("t6_irq", 32'(irq), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
